// File: rtl/spi_slave_axi_arbiter.sv
// Round-robin arbiter sharing one 64-bit AXI4 master between N_REQ 32-bit
// single-word requesters; one transaction in flight, response routed back to its originator.
module spi_slave_axi_arbiter #(
  parameter int N_REQ          = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0][31:0]    req_addr,
  input  logic [N_REQ-1:0][31:0]    req_wdata,
  input  logic [N_REQ-1:0][3:0]     req_be,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_aw_valid,
  input  logic                      m_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_aw_addr,
  output logic                      m_w_valid,
  input  logic                      m_w_ready,
  output logic [63:0]               m_w_data,
  output logic [7:0]                m_w_strb,
  output logic                      m_w_last,
  input  logic                      m_b_valid,
  output logic                      m_b_ready,
  input  logic [1:0]                m_b_resp,
  output logic                      m_ar_valid,
  input  logic                      m_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr,
  input  logic                      m_r_valid,
  output logic                      m_r_ready,
  input  logic [63:0]               m_r_data,
  input  logic [1:0]                m_r_resp
);

  if (AXI_DATA_WIDTH != 64) begin : g_bad_dw
    $error("spi_slave_axi_arbiter: AXI_DATA_WIDTH must be 64");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("spi_slave_axi_arbiter: N_REQ must be 2..8");
  end

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_RESP, RSP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, gidx_q, gnt_idx;
  logic            gnt_any;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0]     addr_q, wdata_q, rdata_q, addr_al;
  logic [3:0]      be_q;
  logic            err_q;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    logic [PW:0] k;
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = {1'b0, ptr_q} + (PW+1)'(i);
      if (k >= (PW+1)'(N_REQ)) k = k - (PW+1)'(N_REQ);
      if (!gnt_any && req_valid[k[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = k[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    aw_done_d = aw_done_q | (m_aw_valid & m_aw_ready);
    w_done_d  = w_done_q  | (m_w_valid  & m_w_ready);
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (gnt_any) begin
          // gated so a held req_valid sees no accept while reset is asserted
          req_ready[gnt_idx] = axi_aresetn;
          state_d = req_we[gnt_idx] ? WR : RD_ADDR;
        end
      end
      WR:      if (aw_done_d && w_done_d) state_d = WR_RESP;
      WR_RESP: if (m_b_valid)  state_d = RSP;
      RD_ADDR: if (m_ar_ready) state_d = RD_RESP;
      RD_RESP: if (m_r_valid)  state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == IDLE && gnt_any) begin
        gidx_q  <= gnt_idx;
        ptr_q   <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        addr_q  <= req_addr[gnt_idx];
        wdata_q <= req_wdata[gnt_idx];
        be_q    <= req_be[gnt_idx];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == WR_RESP && m_b_valid) err_q <= |m_b_resp;
      if (state_q == RD_RESP && m_r_valid) begin
        rdata_q <= addr_q[2] ? m_r_data[63:32] : m_r_data[31:0];
        err_q   <= |m_r_resp;
      end
    end
  end

  assign addr_al    = {addr_q[31:2], 2'b00};
  assign m_aw_addr  = AXI_ADDR_WIDTH'(addr_al);
  assign m_ar_addr  = AXI_ADDR_WIDTH'(addr_al);
  assign m_aw_valid = (state_q == WR) && !aw_done_q;
  assign m_w_valid  = (state_q == WR) && !w_done_q;
  assign m_w_data   = addr_q[2] ? {wdata_q, 32'h0} : {32'h0, wdata_q};
  assign m_w_strb   = addr_q[2] ? {be_q, 4'h0} : {4'h0, be_q};
  assign m_w_last   = 1'b1;
  assign m_b_ready  = (state_q == WR_RESP);
  assign m_ar_valid = (state_q == RD_ADDR);
  assign m_r_ready  = (state_q == RD_RESP);
  assign rsp_rdata  = (state_q == RSP) ? rdata_q : '0;
  assign rsp_err    = (state_q == RSP) && err_q;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RSP) rsp_valid[gidx_q] = 1'b1;
  end

  a_onehot: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    $onehot0({req_ready, rsp_valid}));
  a_aw_ar_excl: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(m_aw_valid && m_ar_valid));
  a_aw_hold: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    m_aw_valid && !m_aw_ready |=> m_aw_valid);
  a_w_hold: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    m_w_valid && !m_w_ready |=> m_w_valid);
  a_ar_hold: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    m_ar_valid && !m_ar_ready |=> m_ar_valid);

endmodule

// File: tb/tb_spi_slave_axi_arbiter.sv
// Directed bench: vector table for single transactions plus sequences for
// fairness, slave stalls and mid-transaction reset.
module tb_spi_slave_axi_arbiter;
  localparam int N = 2;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][31:0] req_addr, req_wdata;
  logic [N-1:0][3:0] req_be;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
  logic              m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [31:0]       m_aw_addr, m_ar_addr;
  logic [63:0]       m_w_data, m_r_data;
  logic [7:0]        m_w_strb;
  logic [1:0]        m_b_resp, m_r_resp;

  always #5 axi_aclk = ~axi_aclk;

  spi_slave_axi_arbiter #(.N_REQ(N), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp)
  );

  // Slave model: each ready/valid answers after a programmable number of wait cycles.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [1:0]  b_resp_c = 2'b00, r_resp_c = 2'b00;
  logic [63:0] r_data_c = '0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_cnt = 0, cyc = 0;
  logic [31:0] last_aw = '0, last_ar = '0;
  logic [63:0] last_wd = '0;
  logic [7:0]  last_strb = '0;

  assign m_aw_ready = m_aw_valid && (aw_cnt >= aw_dly);
  assign m_w_ready  = m_w_valid  && (w_cnt  >= w_dly);
  assign m_ar_ready = m_ar_valid && (ar_cnt >= ar_dly);
  assign m_b_valid  = m_b_ready  && (b_cnt  >= b_dly);
  assign m_r_valid  = m_r_ready  && (r_cnt  >= r_dly);
  assign m_b_resp   = b_resp_c;
  assign m_r_resp   = r_resp_c;
  assign m_r_data   = r_data_c;

  always @(posedge axi_aclk) begin
    cyc    <= cyc + 1;
    aw_cnt <= (m_aw_valid && !m_aw_ready) ? aw_cnt + 1 : 0;
    w_cnt  <= (m_w_valid  && !m_w_ready)  ? w_cnt + 1  : 0;
    ar_cnt <= (m_ar_valid && !m_ar_ready) ? ar_cnt + 1 : 0;
    b_cnt  <= (m_b_ready  && !m_b_valid)  ? b_cnt + 1  : 0;
    r_cnt  <= (m_r_ready  && !m_r_valid)  ? r_cnt + 1  : 0;
    if (m_aw_valid && m_aw_ready) begin aw_hs <= aw_hs + 1; last_aw <= m_aw_addr; end
    if (m_w_valid && m_w_ready) begin w_hs <= w_hs + 1; last_wd <= m_w_data; last_strb <= m_w_strb; end
    if (m_ar_valid && m_ar_ready) begin ar_hs <= ar_hs + 1; last_ar <= m_ar_addr; end
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Issue one request from requester idx and wait for its response pulse.
  task automatic txn(input int idx, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output bit er, output int lat);
    int n, t0;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge axi_aclk);
    req_valid[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = a;
    req_wdata[idx] = wd;   req_be[idx] = be;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 50) begin @(negedge axi_aclk); #1; n++; end
    chk("grant_timeout", 64'(n < 50), 64'd1);
    t0 = cyc;
    @(negedge axi_aclk);
    req_valid[idx] = 1'b0;
    n = 0;
    while (!rsp_valid[idx] && n < 50) begin @(negedge axi_aclk); n++; end
    chk("rsp_timeout", 64'(n < 50), 64'd1);
    chk("rsp_route", 64'(rsp_valid), 64'd1 << idx);
    lat = cyc - t0; rd = rsp_rdata; er = rsp_err;
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [63:0] rdat;
    logic [1:0]  bresp, rresp;
    logic [31:0] exp_addr, exp_rd;
    bit          exp_err;
    logic [63:0] exp_wd;
    logic [7:0]  exp_strb;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, h_aw, h_w, h_ar, h_rsp, n;
    int gq[$], gc[$], rq[$];

    vt[0] = '{0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, 64'h0, 2'b00, 2'b00, 32'h1004, 32'h0, 0, 64'hDEADBEEF_00000000, 8'hF0};
    vt[1] = '{1, 0, 32'h2000, 32'h0, 4'h0, 64'h11112222_33334444, 2'b00, 2'b00, 32'h2000, 32'h33334444, 0, 64'h0, 8'h0};
    vt[2] = '{1, 0, 32'h2004, 32'h0, 4'h0, 64'h11112222_33334444, 2'b00, 2'b00, 32'h2004, 32'h11112222, 0, 64'h0, 8'h0};
    vt[3] = '{0, 1, 32'h1003, 32'hA5A50001, 4'h3, 64'h0, 2'b00, 2'b00, 32'h1000, 32'h0, 0, 64'h00000000_A5A50001, 8'h03};
    vt[4] = '{1, 1, 32'h0010, 32'h12345678, 4'hC, 64'h0, 2'b10, 2'b00, 32'h0010, 32'h0, 1, 64'h00000000_12345678, 8'h0C};
    vt[5] = '{0, 0, 32'h3004, 32'h0, 4'h0, 64'hCAFEF00D_0BADBEEF, 2'b00, 2'b11, 32'h3004, 32'hCAFEF00D, 1, 64'h0, 8'h0};
    vt[6] = '{1, 0, 32'h0008, 32'h0, 4'h0, 64'h01020304_05060708, 2'b00, 2'b01, 32'h0008, 32'h05060708, 1, 64'h0, 8'h0};

    // Reset state, with requests pending to show req_ready stays low.
    req_valid = '1; req_we = '1; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(negedge axi_aclk);
    chk("rst_ctrl", 64'({req_ready, rsp_valid, rsp_err, m_aw_valid, m_w_valid, m_w_last,
                        m_b_ready, m_ar_valid, m_r_ready}), 64'b0000_0_0_0_1_0_0_0);
    chk("rst_data", {m_w_data[31:0], m_aw_addr | m_ar_addr | rsp_rdata | 32'(m_w_strb)}, 64'd0);
    req_valid = '0;
    axi_aresetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      b_resp_c = vt[v].bresp; r_resp_c = vt[v].rresp; r_data_c = vt[v].rdat;
      h_aw = aw_hs; h_w = w_hs; h_ar = ar_hs; h_rsp = rsp_cnt;
      txn(vt[v].idx, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].be, rd, er, lat);
      @(negedge axi_aclk);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'd3);
      chk($sformatf("v%0d_rdata", v), 64'(rd), 64'(vt[v].exp_rd));
      chk($sformatf("v%0d_err", v), 64'(er), 64'(vt[v].exp_err));
      chk($sformatf("v%0d_rsp_count", v), 64'(rsp_cnt - h_rsp), 64'd1);
      if (vt[v].we) begin
        chk($sformatf("v%0d_aw_addr", v), 64'(last_aw), 64'(vt[v].exp_addr));
        chk($sformatf("v%0d_w_data", v), last_wd, vt[v].exp_wd);
        chk($sformatf("v%0d_w_strb", v), 64'(last_strb), 64'(vt[v].exp_strb));
        chk($sformatf("v%0d_aw_w_hs", v), 64'({aw_hs - h_aw, w_hs - h_w}), {32'd1, 32'd1});
      end else begin
        chk($sformatf("v%0d_ar_addr", v), 64'(last_ar), 64'(vt[v].exp_addr));
        chk($sformatf("v%0d_ar_hs", v), 64'(ar_hs - h_ar), 64'd1);
      end
    end

    // Fairness: both requesters held valid, pointer is at 0 after vt[6].
    b_resp_c = 2'b00; r_resp_c = 2'b00; r_data_c = 64'h0;
    @(negedge axi_aclk);
    req_we = '0; req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_valid = '1;
    #1;
    n = 0;
    while (rq.size() < 6 && n < 60) begin
      if (|req_ready) begin gq.push_back(req_ready[1] ? 1 : 0); gc.push_back(cyc); end
      if (|rsp_valid) rq.push_back(rsp_valid[1] ? 1 : 0);
      if (rq.size() < 6) begin @(negedge axi_aclk); #1; end
      n++;
    end
    req_valid = '0;
    chk("rr_grant_count", 64'(gq.size()), 64'd6);
    chk("rr_rsp_count", 64'(rq.size()), 64'd6);
    if (gq.size() == 6 && rq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr_grant%0d", i), 64'(gq[i]), 64'(i % 2));
        chk($sformatf("rr_rsp%0d", i), 64'(rq[i]), 64'(i % 2));
      end
      chk("rr_spacing", 64'(gc[5] - gc[0]), 64'd20);
    end
    @(negedge axi_aclk);

    // Slave stalls: AW waits 3 cycles, B waits 5, W immediate.
    aw_dly = 3; b_dly = 5;
    h_aw = aw_hs; h_w = w_hs; h_rsp = rsp_cnt;
    txn(0, 1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, lat);
    @(negedge axi_aclk);
    chk("stall_latency", 64'(lat), 64'd11);
    chk("stall_aw_hs", 64'(aw_hs - h_aw), 64'd1);
    chk("stall_w_hs", 64'(w_hs - h_w), 64'd1);
    chk("stall_rsp_count", 64'(rsp_cnt - h_rsp), 64'd1);
    chk("stall_w_data", last_wd, 64'h00000000_0BADF00D);
    aw_dly = 0; b_dly = 0;

    // Reset asserted in RD_RESP; pointer (1 before reset) must restart at 0.
    r_dly = 100;
    @(negedge axi_aclk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h100;
    #1;
    n = 0;
    while (!req_ready[0] && n < 10) begin @(negedge axi_aclk); #1; n++; end
    @(negedge axi_aclk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!m_r_ready && n < 10) begin @(negedge axi_aclk); n++; end
    chk("rd_resp_reached", 64'(m_r_ready), 64'd1);
    axi_aresetn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({req_ready, rsp_valid, m_aw_valid, m_w_valid, m_w_last,
                           m_b_ready, m_ar_valid, m_r_ready}), 64'b00_00_0_0_1_0_0_0);
    repeat (2) @(negedge axi_aclk);
    r_dly = 0;
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    req_valid = '1;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'b01);
    @(negedge axi_aclk);
    req_valid = '0;
    n = 0;
    while (!(|rsp_valid) && n < 20) begin @(negedge axi_aclk); n++; end
    chk("post_rst_rsp", 64'(rsp_valid), 64'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
